// File: rtl/card_dealer_pkg.sv
// Shared ten-and-a-half definitions: card ranges, deck size, game/dealer state encodings.
// Also holds the slot-to-card-value helper used by the dealer.
package card_dealer_pkg;

  localparam int CARD_MIN       = 1;
  localparam int CARD_MAX       = 13;
  localparam int DECK_SIZE      = 52;
  localparam int HALF_POINT_MIN = 11;  // J/Q/K count as half a point

  typedef enum logic [2:0] {
    GS_IDLE,
    GS_PLAYER,
    GS_DEALER,
    GS_PLAYER_BUST,
    GS_DEALER_BUST,
    GS_PLAYER_WIN,
    GS_DEALER_WIN,
    GS_TIE
  } game_state_e;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_PICK,
    DS_PROBE,
    DS_DEAL
  } dealer_state_e;

  // Deck slot 0..51 -> card value (slot mod 13) + 1, without a divider.
  function automatic logic [3:0] slot_value(input logic [5:0] slot);
    logic [5:0] r;
    r = slot;
    if (r >= 6'd39)      r = r - 6'd39;
    else if (r >= 6'd26) r = r - 6'd26;
    else if (r >= 6'd13) r = r - 6'd13;
    return r[3:0] + 4'd1;
  endfunction

endpackage

// File: rtl/card_dealer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), one step per enabled cycle.
// Exposes only the low OUT_W bits; no backpressure.
module card_lfsr16 #(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [OUT_W-1:0] value
);

  logic [15:0] lfsr_q;
  logic        fb;

  assign fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign value = lfsr_q[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst)     lfsr_q <= SEED;
    else if (en) lfsr_q <= {lfsr_q[14:0], fb};
  end

endmodule

// File: rtl/card_dealer.sv
// Deals one card per pip rising edge from a 52-slot no-repeat deck; valid 2+k cycles after the edge.
// One request arriving while busy is held in pending, later ones are dropped; empty deck auto-reshuffles.
module card_dealer #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter bit          FIXED_ORDER = 1'b0,
  parameter int          DECK_SIZE   = 52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pip,
  input  logic       new_deck,
  output logic [3:0] number,
  output logic       valid,
  output logic       busy,
  output logic [5:0] cards_left,
  output logic       reshuffled
);
  import card_dealer_pkg::*;

  localparam logic [1:0] IDLE  = DS_IDLE;
  localparam logic [1:0] PICK  = DS_PICK;
  localparam logic [1:0] PROBE = DS_PROBE;
  localparam logic [1:0] DEAL  = DS_DEAL;

  localparam logic [5:0] FULL      = 6'(DECK_SIZE);
  localparam logic [5:0] LAST_SLOT = 6'(DECK_SIZE - 1);

  logic [1:0]           state;
  logic [DECK_SIZE-1:0] used;
  logic [5:0]           idx;
  logic [5:0]           start_idx;
  logic [5:0]           rnd;
  logic                 pip_d;
  logic                 pending;
  logic                 req;
  logic                 auto_clear;

  card_lfsr16 #(
    .SEED  (LFSR_SEED),
    .OUT_W (6)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .value (rnd)
  );

  assign req        = pip & ~pip_d;
  assign auto_clear = (state == PICK) && (cards_left == 6'd0);
  assign reshuffled = auto_clear && !new_deck;
  assign valid      = (state == DEAL);
  assign busy       = (state != IDLE);
  assign number     = valid ? slot_value(idx) : 4'd0;

  // Fold the 6-bit random value 52..63 back onto 0..11.
  always_comb begin
    start_idx = 6'd0;
    if (!FIXED_ORDER) start_idx = (rnd >= FULL) ? rnd - FULL : rnd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      used       <= '0;
      idx        <= 6'd0;
      pip_d      <= 1'b0;
      pending    <= 1'b0;
      cards_left <= FULL;
    end else begin
      pip_d <= pip;
      if (new_deck) begin
        // A simultaneous edge survives the abort and is served from the fresh deck.
        state      <= IDLE;
        used       <= '0;
        cards_left <= FULL;
        pending    <= req;
      end else begin
        if (req && state != IDLE) pending <= 1'b1;
        case (state)
          IDLE: begin
            if (req || pending) begin
              pending <= 1'b0;
              state   <= PICK;
            end
          end
          PICK: begin
            if (auto_clear) begin
              used       <= '0;
              cards_left <= FULL;
            end
            idx   <= start_idx;
            state <= PROBE;
          end
          PROBE: begin
            // cards_left > 0 here, so a free slot is reached within one lap.
            if (!used[idx]) begin
              used[idx]  <= 1'b1;
              cards_left <= cards_left - 6'd1;
              state      <= DEAL;
            end else begin
              idx <= (idx == LAST_SLOT) ? 6'd0 : idx + 6'd1;
            end
          end
          DEAL:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench: one fixed-order and one LFSR-order dealer side by side, checked against hand-derived values
// and a small reference model of the LFSR start index and slot probing.
module tb_card_dealer;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       f_pip = 1'b0, f_nd = 1'b0, r_pip = 1'b0, r_nd = 1'b0;
  logic [3:0] f_num, r_num;
  logic       f_valid, r_valid, f_busy, r_busy, f_resh, r_resh;
  logic [5:0] f_left, r_left_o;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_lfsr;
  bit          r_used [52];
  int          r_left;
  int          rec    [8];
  int          vcount [14];

  always #5 clk = ~clk;

  always @(posedge clk)
    m_lfsr <= rst ? SEED : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  card_dealer #(.LFSR_SEED(SEED), .FIXED_ORDER(1'b1), .DECK_SIZE(52)) dut_fix (
    .clk(clk), .rst(rst), .pip(f_pip), .new_deck(f_nd), .number(f_num), .valid(f_valid),
    .busy(f_busy), .cards_left(f_left), .reshuffled(f_resh));

  card_dealer #(.LFSR_SEED(SEED), .FIXED_ORDER(1'b0), .DECK_SIZE(52)) dut_rnd (
    .clk(clk), .rst(rst), .pip(r_pip), .new_deck(r_nd), .number(r_num), .valid(r_valid),
    .busy(r_busy), .cards_left(r_left_o), .reshuffled(r_resh));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_checks(input string p);
    chk({p, "_f_number"}, 32'(f_num), 0);
    chk({p, "_f_valid"}, 32'(f_valid), 0);
    chk({p, "_f_busy"}, 32'(f_busy), 0);
    chk({p, "_f_resh"}, 32'(f_resh), 0);
    chk({p, "_f_left"}, 32'(f_left), 52);
    chk({p, "_r_number"}, 32'(r_num), 0);
    chk({p, "_r_valid"}, 32'(r_valid), 0);
    chk({p, "_r_busy"}, 32'(r_busy), 0);
    chk({p, "_r_left"}, 32'(r_left_o), 52);
  endtask

  task automatic clear_model();
    foreach (r_used[j]) r_used[j] = 1'b0;
    r_left = 52;
  endtask

  // One-cycle pip pulse from a negedge; lat counts cycles from the req edge to the valid cycle.
  task automatic draw(input bit rnd, output int lat, output int num, output int left,
                      output int resh, output logic [15:0] snap);
    int  cnt;
    bit  seen;
    cnt = 0; seen = 0; resh = 0; lat = -1; num = 0; left = -1; snap = '0;
    if (rnd) r_pip = 1'b1; else f_pip = 1'b1;
    while (!seen && cnt < 80) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        snap = m_lfsr;
        if (rnd) r_pip = 1'b0; else f_pip = 1'b0;
      end
      if (rnd ? r_resh : f_resh) resh++;
      if (rnd ? r_valid : f_valid) begin
        seen = 1;
        lat  = cnt - 1;
        num  = int'(rnd ? r_num : f_num);
        left = int'(rnd ? r_left_o : f_left);
      end
    end
    if (!seen) chk("draw_timeout", 0, 1);
    else begin
      @(negedge clk);
      chk("valid_one_cycle", 32'(rnd ? r_valid : f_valid), 0);
      chk("number_zero_after", 32'(rnd ? r_num : f_num), 0);
    end
  endtask

  task automatic model_draw(input logic [15:0] s, output int exp_num, output int exp_lat);
    int i, k;
    if (r_left == 0) clear_model();
    i = int'(s[5:0]);
    if (i >= 52) i -= 52;
    k = 0;
    while (r_used[i]) begin
      i = (i == 51) ? 0 : i + 1;
      k++;
    end
    r_used[i] = 1'b1;
    r_left--;
    exp_num = i % 13 + 1;
    exp_lat = 2 + k;
  endtask

  task automatic rnd_step(output int num);
    int lat, left, resh, en, el;
    logic [15:0] snap;
    draw(1'b1, lat, num, left, resh, snap);
    model_draw(snap, en, el);
    chk("rnd_number", 32'(num), 32'(en));
    chk("rnd_latency", 32'(lat), 32'(el));
    chk("rnd_left", 32'(left), 32'(r_left));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int lat, num, left, resh, nv, zbad, resh_total;
    int pv [4];
    logic [15:0] snap;

    @(negedge clk);
    idle_checks("reset");
    rst = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rnd_step(num);
      rec[i] = num;
    end

    // Fixed order: one full deck in index order.
    resh_total = 0;
    for (int i = 0; i < 52; i++) begin
      draw(1'b0, lat, num, left, resh, snap);
      chk("fix_number", 32'(num), 32'(i % 13 + 1));
      chk("fix_latency", 32'(lat), 32'(i + 2));
      chk("fix_left", 32'(left), 32'(51 - i));
      resh_total += resh;
      repeat (3) @(negedge clk);
    end
    chk("fix_no_early_reshuffle", 32'(resh_total), 0);
    chk("fix_exhausted", 32'(f_left), 0);

    draw(1'b0, lat, num, left, resh, snap);
    chk("resh_pulse", 32'(resh), 1);
    chk("resh_number", 32'(num), 1);
    chk("resh_left", 32'(left), 51);
    chk("resh_latency", 32'(lat), 2);
    repeat (3) @(negedge clk);

    // Level-held pip yields one card (slot 1).
    f_pip = 1'b1; nv = 0; num = 0; zbad = 0;
    for (int s = 0; s < 80; s++) begin
      if (s == 20) f_pip = 1'b0;
      @(negedge clk);
      if (f_valid) begin nv++; num = int'(f_num); end
      else if (f_num != 4'd0) zbad++;
    end
    chk("hold_count", 32'(nv), 1);
    chk("hold_number", 32'(num), 2);
    chk("hold_left", 32'(f_left), 50);

    // Three edges: second pends during busy, third is dropped while pending.
    nv = 0; pv = '{0, 0, 0, 0};
    for (int s = 0; s < 150; s++) begin
      f_pip = (s == 0 || s == 2 || s == 4);
      @(negedge clk);
      if (f_valid) begin
        if (nv < 4) pv[nv] = int'(f_num);
        nv++;
      end else if (f_num != 4'd0) zbad++;
    end
    chk("pend_count", 32'(nv), 2);
    chk("pend_first", 32'(pv[0]), 3);
    chk("pend_second", 32'(pv[1]), 4);
    chk("pend_left", 32'(f_left), 48);
    chk("number_zero_when_invalid", 32'(zbad), 0);

    // new_deck while idle, 30 draws, then abort a draw in PROBE.
    f_nd = 1'b1;
    @(negedge clk);
    f_nd = 1'b0;
    chk("nd_idle_left", 32'(f_left), 52);
    for (int i = 0; i < 30; i++) begin
      draw(1'b0, lat, num, left, resh, snap);
      chk("nd_pre_number", 32'(num), 32'(i % 13 + 1));
      @(negedge clk);
    end
    chk("nd_pre_left", 32'(f_left), 22);
    f_pip = 1'b1; nv = 0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (c == 1) f_pip = 1'b0;
      if (c == 5) f_nd = 1'b1;
      if (c == 6) f_nd = 1'b0;
      if (f_valid) nv++;
    end
    chk("nd_no_valid", 32'(nv), 0);
    chk("nd_left", 32'(f_left), 52);
    chk("nd_busy", 32'(f_busy), 0);
    draw(1'b0, lat, num, left, resh, snap);
    chk("nd_next_number", 32'(num), 1);
    chk("nd_next_latency", 32'(lat), 2);
    chk("nd_next_left", 32'(left), 51);
    repeat (3) @(negedge clk);

    // Reset in the middle of a probe walk.
    for (int i = 0; i < 2; i++) begin
      draw(1'b0, lat, num, left, resh, snap);
      chk("pre_rst_number", 32'(num), 32'(i + 2));
      @(negedge clk);
    end
    f_pip = 1'b1;
    @(negedge clk);
    f_pip = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    idle_checks("midrst");
    rst = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);

    // Same timing after reset: LFSR order must repeat, then finish the random deck.
    foreach (vcount[v]) vcount[v] = 0;
    for (int i = 0; i < 52; i++) begin
      rnd_step(num);
      if (i < 8) chk("replay_number", 32'(num), 32'(rec[i]));
      if (num >= 1 && num <= 13) vcount[num]++;
    end
    for (int v = 1; v <= 13; v++) chk("rnd_value_count", 32'(vcount[v]), 4);
    chk("rnd_left_end", 32'(r_left_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Card source for the ten-and-a-half game controller; answers its draw request (`pip`) with one card value (`number`).
- Models a 52-card deck: 4 suits × values 1..13.
- No card repeats until the deck is exhausted. The deck then reshuffles automatically.
- Random order comes from a free-running LFSR; a fixed-order mode gives deterministic verification.

Parameters:
- LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR; must be non-zero.
- FIXED_ORDER, 0, 1 = candidate index is always 0, so cards deal in index order 0,1,2,...; 0 = LFSR-derived start index.
- DECK_SIZE, 52, number of card slots; fixed at 52; index i maps to value (i mod 13)+1.

Ports:
- clk  in  1  game control clock (the slow divided clock in the top level)
- rst  in  1  synchronous, active-high reset
- pip  in  1  draw request; level signal, each 0→1 transition requests exactly one card
- new_deck  in  1  one-cycle pulse; clears the used-card bitmap and aborts any draw in progress
- number  out  4  dealt card 1..13 while valid=1; 4'd0 at all other times
- valid  out  1  one-cycle pulse marking number
- busy  out  1  high from request acceptance until the cycle valid is high, inclusive
- cards_left  out  6  undealt cards remaining, 52..0
- reshuffled  out  1  one-cycle pulse when an exhausted deck is auto-cleared

Behaviour:
- Single clock domain; all state changes on posedge clk. Reset is synchronous, active-high.
- Reset values:
  - number=0, valid=0, busy=0, reshuffled=0, cards_left=52
  - used bitmap all 0, lfsr=LFSR_SEED, pip_d=0, pending=0, state=IDLE
- Edge detection:
  - req = pip & ~pip_d, with pip_d registered every cycle.
  - Holding pip high for many cycles yields exactly one card.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle, including while idle.
- State machine:
  - IDLE: on req or pending, clear pending and go to PICK; busy=1 from the next cycle.
  - PICK:
    - If cards_left==0: clear bitmap, set cards_left=52, pulse reshuffled.
    - Load idx: FIXED_ORDER ? 0 : (lfsr[5:0]≥52 ? lfsr[5:0]-52 : lfsr[5:0]).
    - Go to PROBE.
  - PROBE:
    - If used[idx]==0: set used[idx], decrement cards_left, go to DEAL.
    - Else idx = (idx==51) ? 0 : idx+1 and stay. Wrap 51→0 is mandatory.
    - At most 52 probe cycles, guaranteed because cards_left>0.
  - DEAL:
    - number=(idx mod 13)+1, valid=1, busy=1 for this single cycle; return to IDLE.
    - number and valid drop to 0 the next cycle.
- Latency: req sampled at edge T → PICK at T+1 → valid at T+2+k, where k = number of occupied slots skipped (0..51).
- Request while busy:
  - One req is latched into pending and served immediately after DEAL.
  - Further reqs while pending=1 are dropped.
- new_deck:
  - Highest priority below rst.
  - Effects: bitmap cleared, cards_left=52, pending=0, state=IDLE, no valid pulse for the aborted draw.
  - If new_deck arrives in DEAL, the valid pulse for that cycle still occurs, but the bitmap is cleared afterwards.
  - req in the same cycle as new_deck: the request is accepted after the clear.
- Simultaneous deck exhaustion and new_deck: new_deck wins; reshuffled is not pulsed.
- cards_left never underflows; it is reloaded only in PICK (auto) or by new_deck.
- number is 0 whenever valid=0, so the consumer may test number!=0 as the valid indication.

Decomposition:
- Shared game package holds:
  - CARD_MIN=1, CARD_MAX=13, DECK_SIZE=52, HALF_POINT_MIN=11 (J/Q/K)
  - the 3-bit game state encoding
  - the dealer state enum {IDLE, PICK, PROBE, DEAL}
- One natural sub-module: card_lfsr16, a 16-bit LFSR with seed parameter and enable. Its output is only consumed in PICK.
- Bitmap, probe and FSM stay in card_dealer.

Test Plan:
- FIXED_ORDER=1, reset, 1-cycle pip pulses spaced 60 cycles → values 1..13,1..13,... for 52 draws; each valid exactly 1 cycle; cards_left 51→0; latency of the i-th draw = i+1 cycles past T+1.
- FIXED_ORDER=1, 53rd pip after exhaustion → reshuffled pulse in PICK; number=1; cards_left=51.
- pip held high 20 cycles, then low → exactly one valid pulse; second pip edge during busy → second card follows directly after first DEAL; a third edge while pending → dropped, total 2 cards.
- FIXED_ORDER=0, SEED=16'hACE1, 52 draws → each value 1..13 seen exactly 4 times; no index repeats; cards_left=0.
- new_deck asserted in a PROBE cycle after 30 draws → no valid for that draw; cards_left=52; next pip (FIXED_ORDER=1) yields number=1.
- rst asserted mid-PROBE → next cycle: all outputs 0, cards_left=52, busy=0; LFSR restarts at seed, reproducing the first-run sequence.
